// File: rtl/ibex_fetch_fifo_circ_pkg.sv
// Shared types and helpers for the circular instruction fetch FIFO.
// Holds the storage entry layout and the RVC length decode.
package ibex_fetch_fifo_circ_pkg;

  localparam int unsigned FetchWidth = 32;

  typedef struct packed {
    logic [FetchWidth-1:0] rdata;
    logic                  err;
  } fetch_entry_t;

  // RVC encodings use any low-bit pattern except 2'b11.
  function automatic logic fetch_is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_fifo_circ_aligner.sv
// Combinational realigner: turns the head/next fetch words and the halfword
// address bit into one 16/32-bit instruction plus the consume/advance controls.
module ibex_fetch_fifo_circ_aligner
  import ibex_fetch_fifo_circ_pkg::*;
(
  input  logic [31:0] i_head_rdata,
  input  logic        i_head_err,
  input  logic        i_head_avail,
  input  logic [15:0] i_next_lo,
  input  logic        i_next_err,
  input  logic        i_next_avail,
  input  logic        i_addr1,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_err_plus2,
  output logic        o_incr_two,
  output logic        o_pop_head
);

  logic w_compressed;

  always_comb begin
    w_compressed = 1'b0;
    o_valid      = 1'b0;
    o_rdata      = '0;
    o_err        = 1'b0;
    o_err_plus2  = 1'b0;
    o_pop_head   = 1'b0;
    if (!i_addr1) begin
      // An erroneous word is treated as 32-bit so the whole word is retired.
      w_compressed = fetch_is_compressed(i_head_rdata[1:0]) & ~i_head_err;
      o_valid      = i_head_avail;
      o_rdata      = i_head_rdata;
      o_err        = i_head_err;
      o_err_plus2  = 1'b0;
      o_pop_head   = ~w_compressed;
    end else begin
      w_compressed = fetch_is_compressed(i_head_rdata[17:16]) | i_head_err;
      o_valid      = w_compressed ? i_head_avail : (i_head_avail & i_next_avail);
      o_rdata      = {i_next_lo, i_head_rdata[31:16]};
      o_err        = i_head_err | (i_next_err & ~w_compressed);
      o_err_plus2  = i_next_err & ~i_head_err;
      o_pop_head   = 1'b1;
    end
  end

  assign o_incr_two = w_compressed;

endmodule

// File: rtl/ibex_fetch_fifo_circ.sv
// Circular-buffer instruction fetch FIFO with RVC realignment, empty bypass,
// free-entry credits, busy thermometer and a sticky overflow flag.
module ibex_fetch_fifo_circ
  import ibex_fetch_fifo_circ_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned DEPTH    = 3,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  output logic [NUM_REQS-1:0]        busy_o,
  output logic [$clog2(DEPTH+1)-1:0] free_o,
  output logic                       overflow_o,
  input  logic                       in_valid_i,
  input  logic [31:0]                in_addr_i,
  input  logic [31:0]                in_rdata_i,
  input  logic                       in_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_addr_o,
  output logic [31:0]                out_rdata_o,
  output logic                       out_err_o,
  output logic                       out_err_plus2_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  if (DEPTH < NUM_REQS + 1) begin : g_depth_check
    $error("DEPTH must be at least NUM_REQS+1");
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic [30:0]     r_addr;
  logic            r_overflow;

  logic [PtrW-1:0] w_rd_ptr_inc;
  logic [31:0]     w_head_rdata;
  logic            w_head_err, w_head_avail;
  logic [15:0]     w_next_lo;
  logic            w_next_err, w_next_avail;
  logic            w_incr_two, w_pop_head;
  logic            w_fire, w_pop, w_bypass, w_push_req, w_push, w_drop, w_full;
  logic            w_unused;

  assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);
  assign w_full       = (r_count == CntW'(DEPTH));

  // Empty FIFO presents the incoming word directly as the head.
  always_comb begin
    w_head_rdata = in_rdata_i;
    w_head_err   = in_err_i;
    w_next_lo    = '0;
    w_next_err   = 1'b0;
    if (r_count != '0) begin
      w_head_rdata = r_mem[r_rd_ptr].rdata;
      w_head_err   = r_mem[r_rd_ptr].err;
    end
    if (r_count > CntW'(1)) begin
      w_next_lo  = r_mem[w_rd_ptr_inc].rdata[15:0];
      w_next_err = r_mem[w_rd_ptr_inc].err;
    end else if (r_count == CntW'(1)) begin
      w_next_lo  = in_rdata_i[15:0];
      w_next_err = in_err_i;
    end
  end

  assign w_head_avail = (r_count != '0) | in_valid_i;
  assign w_next_avail = (r_count > CntW'(1)) | ((r_count == CntW'(1)) & in_valid_i);

  ibex_fetch_fifo_circ_aligner u_aligner (
    .i_head_rdata (w_head_rdata),
    .i_head_err   (w_head_err),
    .i_head_avail (w_head_avail),
    .i_next_lo    (w_next_lo),
    .i_next_err   (w_next_err),
    .i_next_avail (w_next_avail),
    .i_addr1      (r_addr[0]),
    .o_valid      (out_valid_o),
    .o_rdata      (out_rdata_o),
    .o_err        (out_err_o),
    .o_err_plus2  (out_err_plus2_o),
    .o_incr_two   (w_incr_two),
    .o_pop_head   (w_pop_head)
  );

  assign w_fire     = out_valid_o & out_ready_i;
  assign w_pop      = w_fire & w_pop_head & (r_count != '0);
  // With an empty FIFO a head-retiring fire consumes the incoming word outright.
  assign w_bypass   = w_fire & w_pop_head & (r_count == '0);
  assign w_push_req = in_valid_i & ~w_bypass;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= in_addr_i[31:1];
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      if (w_fire) r_addr <= r_addr + (w_incr_two ? 31'd1 : 31'd2);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  if (ResetAll) begin : g_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_push && !clear_i) begin
        r_mem[r_wr_ptr] <= '{rdata: in_rdata_i, err: in_err_i};
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wr_ptr] <= '{rdata: in_rdata_i, err: in_err_i};
    end
  end

  for (genvar i = 0; i < int'(NUM_REQS); i++) begin : g_busy
    assign busy_o[i] = (r_count >= CntW'(DEPTH - NUM_REQS + 1 + i));
  end

  assign free_o     = CntW'(DEPTH) - r_count;
  assign overflow_o = r_overflow;
  assign out_addr_o = {r_addr, 1'b0};
  assign w_unused   = in_addr_i[0];

endmodule

// File: tb/tb_ibex_fetch_fifo_circ.sv
// Directed bench for ibex_fetch_fifo_circ (DEPTH=3, NUM_REQS=2) with hand-computed expectations.
module tb_ibex_fetch_fifo_circ;

  localparam int unsigned NumReqs = 2;
  localparam int unsigned Depth   = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               clear_i;
  logic [NumReqs-1:0] busy_o;
  logic [1:0]         free_o;
  logic               overflow_o;
  logic               in_valid_i;
  logic [31:0]        in_addr_i;
  logic [31:0]        in_rdata_i;
  logic               in_err_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [31:0]        out_addr_o;
  logic [31:0]        out_rdata_o;
  logic               out_err_o;
  logic               out_err_plus2_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_fetch_fifo_circ #(
    .NUM_REQS (NumReqs),
    .DEPTH    (Depth),
    .ResetAll (1'b0)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .busy_o          (busy_o),
    .free_o          (free_o),
    .overflow_o      (overflow_o),
    .in_valid_i      (in_valid_i),
    .in_addr_i       (in_addr_i),
    .in_rdata_i      (in_rdata_i),
    .in_err_i        (in_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_addr_o      (out_addr_o),
    .out_rdata_o     (out_rdata_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear(input logic [31:0] addr);
    clear_i    = 1'b1;
    in_addr_i  = addr;
    in_valid_i = 1'b0;
    cyc();
    clear_i    = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic err);
    in_valid_i = 1'b1;
    in_rdata_i = data;
    in_err_i   = err;
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_addr_i   = '0;
    in_rdata_i  = '0;
    in_err_i    = 1'b0;
    out_ready_i = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_free", 32'(free_o), 32'd3);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_addr", out_addr_o, 32'h0);

    // 1: zero-latency bypass of an aligned 32-bit word.
    do_clear(32'h80);
    push(32'h0000_0013, 1'b0);
    out_ready_i = 1'b1;
    #1;
    check("s1_valid", 32'(out_valid_o), 32'd1);
    check("s1_addr", out_addr_o, 32'h80);
    check("s1_rdata", out_rdata_o, 32'h0000_0013);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s1_addr_next", out_addr_o, 32'h84);
    check("s1_free", 32'(free_o), 32'd3);
    check("s1_valid_idle", 32'(out_valid_o), 32'd0);
    // Aligned compressed: word kept, then its upper half issued.
    push(32'h0000_4501, 1'b0);
    #1;
    check("s1c_valid", 32'(out_valid_o), 32'd1);
    check("s1c_rdata_lo", 32'(out_rdata_o[15:0]), 32'h4501);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s1c_free", 32'(free_o), 32'd2);
    check("s1c_addr", out_addr_o, 32'h86);
    check("s1c_hi_valid", 32'(out_valid_o), 32'd1);
    check("s1c_hi_rdata", 32'(out_rdata_o[15:0]), 32'h0000);
    cyc();
    check("s1c_free_end", 32'(free_o), 32'd3);
    check("s1c_addr_end", out_addr_o, 32'h88);

    // 2: unaligned 32-bit instruction spanning two words.
    do_clear(32'h102);
    push(32'h0003_0000, 1'b0);
    #1;
    check("s2_wait", 32'(out_valid_o), 32'd0);
    cyc();
    push(32'h0000_2000, 1'b0);
    #1;
    check("s2_valid", 32'(out_valid_o), 32'd1);
    check("s2_addr", out_addr_o, 32'h102);
    check("s2_rdata", out_rdata_o, 32'h2000_0003);
    check("s2_err", 32'(out_err_o), 32'd0);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s2_free_mid", 32'(free_o), 32'd2);
    check("s2_addr_next", out_addr_o, 32'h106);
    check("s2_valid2", 32'(out_valid_o), 32'd1);
    cyc();
    check("s2_free_end", 32'(free_o), 32'd3);
    check("s2_addr_end", out_addr_o, 32'h108);

    // 3: fill, then simultaneous push/pop while full, order across wrap.
    out_ready_i = 1'b0;
    do_clear(32'h200);
    push(32'h1111_1003, 1'b0);
    cyc();
    push(32'h2222_2003, 1'b0);
    cyc();
    check("s3_busy2", 32'(busy_o), 32'b01);
    check("s3_free2", 32'(free_o), 32'd1);
    push(32'h3333_3003, 1'b0);
    cyc();
    push(32'h4444_4003, 1'b0);
    out_ready_i = 1'b1;
    #1;
    check("s3_busy3", 32'(busy_o), 32'b11);
    check("s3_free3", 32'(free_o), 32'd0);
    check("s3_out0", out_rdata_o, 32'h1111_1003);
    check("s3_addr0", out_addr_o, 32'h200);
    cyc();
    push(32'h5555_5003, 1'b0);
    #1;
    check("s3_free_pp", 32'(free_o), 32'd0);
    check("s3_ovf_pp", 32'(overflow_o), 32'd0);
    check("s3_out1", out_rdata_o, 32'h2222_2003);
    check("s3_addr1", out_addr_o, 32'h204);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s3_out2", out_rdata_o, 32'h3333_3003);
    check("s3_addr2", out_addr_o, 32'h208);
    cyc();
    check("s3_out3", out_rdata_o, 32'h4444_4003);
    check("s3_addr3", out_addr_o, 32'h20c);
    cyc();
    check("s3_out4", out_rdata_o, 32'h5555_5003);
    check("s3_addr4", out_addr_o, 32'h210);
    cyc();
    check("s3_empty", 32'(out_valid_o), 32'd0);
    check("s3_free_end", 32'(free_o), 32'd3);

    // 4: overflow when full without pop; sticky until clear.
    out_ready_i = 1'b0;
    do_clear(32'h300);
    push(32'hAAAA_0003, 1'b0);
    cyc();
    push(32'hBBBB_0003, 1'b0);
    cyc();
    push(32'hCCCC_0003, 1'b0);
    cyc();
    check("s4_ovf_pre", 32'(overflow_o), 32'd0);
    push(32'hDDDD_0003, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s4_ovf", 32'(overflow_o), 32'd1);
    check("s4_free", 32'(free_o), 32'd0);
    cyc();
    check("s4_ovf_sticky", 32'(overflow_o), 32'd1);
    out_ready_i = 1'b1;
    #1;
    check("s4_out0", out_rdata_o, 32'hAAAA_0003);
    cyc();
    check("s4_out1", out_rdata_o, 32'hBBBB_0003);
    cyc();
    check("s4_out2", out_rdata_o, 32'hCCCC_0003);
    cyc();
    check("s4_dropped", 32'(out_valid_o), 32'd0);
    check("s4_ovf_hold", 32'(overflow_o), 32'd1);
    do_clear(32'h0);
    #1;
    check("s4_ovf_clr", 32'(overflow_o), 32'd0);
    check("s4_free_clr", 32'(free_o), 32'd3);

    // 5: error attribution on unaligned instructions.
    do_clear(32'h402);
    out_ready_i = 1'b1;
    push(32'h0003_0000, 1'b0);
    cyc();
    push(32'h0000_0000, 1'b1);
    #1;
    check("s5a_valid", 32'(out_valid_o), 32'd1);
    check("s5a_rdata", out_rdata_o, 32'h0000_0003);
    check("s5a_err", 32'(out_err_o), 32'd1);
    check("s5a_plus2", 32'(out_err_plus2_o), 32'd1);
    cyc();
    in_valid_i = 1'b0;
    in_err_i   = 1'b0;
    do_clear(32'h402);
    out_ready_i = 1'b0;
    push(32'h0003_0000, 1'b1);
    #1;
    check("s5b_valid", 32'(out_valid_o), 32'd1);
    check("s5b_err", 32'(out_err_o), 32'd1);
    check("s5b_plus2", 32'(out_err_plus2_o), 32'd0);
    cyc();
    push(32'h0000_0000, 1'b0);
    out_ready_i = 1'b1;
    #1;
    check("s5c_err", 32'(out_err_o), 32'd1);
    check("s5c_plus2", 32'(out_err_plus2_o), 32'd0);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s5c_addr", out_addr_o, 32'h404);

    // 6: asynchronous reset mid-stream.
    out_ready_i = 1'b0;
    do_clear(32'h500);
    push(32'h1234_0003, 1'b0);
    cyc();
    push(32'h5678_0003, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("s6_free_pre", 32'(free_o), 32'd1);
    check("s6_busy_pre", 32'(busy_o), 32'b01);
    #2;
    rst_ni = 1'b0;
    #1;
    check("s6_valid", 32'(out_valid_o), 32'd0);
    check("s6_free", 32'(free_o), 32'd3);
    check("s6_busy", 32'(busy_o), 32'd0);
    check("s6_addr", out_addr_o, 32'h0);
    cyc();
    rst_ni = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
